// File: rtl/eeg_adc_frame_reader_if.sv
// Channel-word stream from the ADC frame reader to the decode pipeline.
// The reader drives through the master modport; the consumer uses the slave modport.
`timescale 1ns/1ps

interface eeg_adc_frame_reader_if #(
    parameter int WORD_BITS = 24
);
    logic [WORD_BITS-1:0] raw_adc_out;
    logic [2:0]           adc_channel_sel;
    logic                 adc_data_ready;

    modport master (
        output raw_adc_out,
        output adc_channel_sel,
        output adc_data_ready
    );

    modport slave (
        input raw_adc_out,
        input adc_channel_sel,
        input adc_data_ready
    );
endinterface

// File: rtl/eeg_adc_frame_reader.sv
// SPI frame reader for an 8-channel 24-bit biopotential ADC: status word plus NUM_CH channel words per DRDY.
// Optional ADC_STATUS_CHECK_EN adds a sync-header check on the status word and a frame_err pulse.
`timescale 1ns/1ps

module eeg_adc_frame_reader #(
    parameter int NUM_CH    = 8,
    parameter int SCLK_DIV  = 4,
    parameter int WORD_BITS = 24
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       enable,
    input  logic                       adc_drdy_n,
    input  logic                       adc_miso,
    input  logic                       clear_overrun,
    output logic                       adc_sclk,
    output logic                       adc_cs_n,
    eeg_adc_frame_reader_if.master     word_if,
    output logic [WORD_BITS-1:0]       frame_status,
    output logic                       frame_overrun,
`ifdef ADC_STATUS_CHECK_EN
    output logic                       frame_err,
`endif
    output logic                       busy
);

    localparam int DIV_W = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
    localparam int BIT_W = (WORD_BITS > 1) ? $clog2(WORD_BITS) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WORD_BITS - 1);
    localparam logic [3:0]       WORD_END = 4'(NUM_CH + 1);

    typedef enum logic [1:0] {
        IDLE,
        CS_SETUP,
        SHIFT,
        CS_HOLD
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [1:0]           drdy_sync;
    logic [1:0]           miso_sync;
    logic                 drdy_prev;
    logic                 drdy_fall;
    logic                 miso_s;
    logic [DIV_W-1:0]     div_cnt;
    logic                 div_last;
    logic                 sclk_phase;
    logic                 phase_next;
    logic                 sclk_next;
    logic                 sample;
    logic                 word_done;
    logic [BIT_W-1:0]     bit_idx;
    logic [3:0]           word_idx;
    logic [WORD_BITS-2:0] shift_reg;
    logic [WORD_BITS-1:0] captured;
    logic                 strobe_ok;

    // DRDY resets to the idle-high level so leaving reset never fakes a falling edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            drdy_sync <= 2'b11;
            drdy_prev <= 1'b1;
            miso_sync <= 2'b00;
        end else begin
            drdy_sync <= {drdy_sync[0], adc_drdy_n};
            drdy_prev <= drdy_sync[1];
            miso_sync <= {miso_sync[0], adc_miso};
        end
    end

    assign drdy_fall = drdy_prev & ~drdy_sync[1];
    assign miso_s    = miso_sync[1];
    assign div_last  = (div_cnt == DIV_LAST);
    assign captured  = {shift_reg, miso_s};
    assign word_done = sample && (bit_idx == BIT_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        phase_next = 1'b1;
        sample     = 1'b0;
        case (state)
            IDLE: begin
                if (drdy_fall && enable) begin
                    state_next = CS_SETUP;
                end
            end
            CS_SETUP: begin
                if (div_last) begin
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                phase_next = div_last ? ~sclk_phase : sclk_phase;
                sample     = sclk_phase && div_last;
                if (div_last && !sclk_phase && (word_idx == WORD_END)) begin
                    state_next = CS_HOLD;
                end
            end
            CS_HOLD: begin
                if (div_last) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        sclk_next = (state_next == SHIFT) && phase_next;
    end

`ifdef ADC_STATUS_CHECK_EN
    logic hdr_bad;

    // A bad sync header poisons the rest of the frame but the SPI read still runs to the end.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hdr_bad   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            if (state == IDLE) begin
                hdr_bad <= 1'b0;
            end else if (word_done && (word_idx == 4'd0)) begin
                hdr_bad   <= (captured[WORD_BITS-1 -: 4] != 4'b1100);
                frame_err <= (captured[WORD_BITS-1 -: 4] != 4'b1100);
            end
        end
    end

    assign strobe_ok = ~hdr_bad;
`else
    assign strobe_ok = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_cnt                 <= '0;
            sclk_phase              <= 1'b1;
            adc_sclk                <= 1'b0;
            adc_cs_n                <= 1'b1;
            busy                    <= 1'b0;
            bit_idx                 <= '0;
            word_idx                <= '0;
            shift_reg               <= '0;
            frame_status            <= '0;
            frame_overrun           <= 1'b0;
            word_if.raw_adc_out     <= '0;
            word_if.adc_channel_sel <= '0;
            word_if.adc_data_ready  <= 1'b0;
        end else begin
            sclk_phase <= phase_next;
            adc_sclk   <= sclk_next;
            adc_cs_n   <= (state_next == IDLE);
            busy       <= (state_next != IDLE);
            div_cnt    <= ((state == IDLE) || div_last) ? '0 : div_cnt + 1'b1;

            if (state == IDLE) begin
                bit_idx  <= '0;
                word_idx <= '0;
            end else if (sample) begin
                shift_reg <= captured[WORD_BITS-2:0];
                if (bit_idx == BIT_LAST) begin
                    bit_idx  <= '0;
                    word_idx <= word_idx + 1'b1;
                end else begin
                    bit_idx <= bit_idx + 1'b1;
                end
            end

            // Word 0 is the status word; words 1..NUM_CH map to channels 0..NUM_CH-1.
            word_if.adc_data_ready <= word_done && (word_idx != 4'd0) && strobe_ok;
            if (word_done && (word_idx == 4'd0)) begin
                frame_status <= captured;
            end
            if (word_done && (word_idx != 4'd0) && strobe_ok) begin
                word_if.raw_adc_out     <= captured;
                word_if.adc_channel_sel <= 3'(word_idx - 4'd1);
            end

            if (drdy_fall && (state != IDLE)) begin
                frame_overrun <= 1'b1;
            end else if (clear_overrun) begin
                frame_overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_eeg_adc_frame_reader.sv
// Directed bench for eeg_adc_frame_reader with a CPHA=1 SPI ADC model.
// Header-check frames are exercised only when ADC_STATUS_CHECK_EN is defined.
`timescale 1ns/1ps

module tb_eeg_adc_frame_reader;

    localparam int NUM_CH    = 8;
    localparam int SCLK_DIV  = 4;
    localparam int WORD_BITS = 24;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        adc_drdy_n = 1'b1;
    logic        adc_miso = 1'b0;
    logic        clear_overrun = 1'b0;
    logic        adc_sclk;
    logic        adc_cs_n;
    logic [23:0] frame_status;
    logic        frame_overrun;
    logic        busy;
`ifdef ADC_STATUS_CHECK_EN
    logic        frame_err;
`endif

    eeg_adc_frame_reader_if #(.WORD_BITS(WORD_BITS)) word_if ();

    eeg_adc_frame_reader #(
        .NUM_CH(NUM_CH),
        .SCLK_DIV(SCLK_DIV),
        .WORD_BITS(WORD_BITS)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .enable(enable),
        .adc_drdy_n(adc_drdy_n),
        .adc_miso(adc_miso),
        .clear_overrun(clear_overrun),
        .adc_sclk(adc_sclk),
        .adc_cs_n(adc_cs_n),
        .word_if(word_if.master),
        .frame_status(frame_status),
        .frame_overrun(frame_overrun),
`ifdef ADC_STATUS_CHECK_EN
        .frame_err(frame_err),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;

    int          tests_run = 0;
    int          tests_failed = 0;
    int          cyc = 0;
    logic [23:0] ch [8];
    logic [215:0] frame_bits = '0;
    logic [215:0] adc_sr = '0;

    int          strobe_sel [$];
    logic [23:0] strobe_data [$];
    int          last_strobe = -1;
    int          bad_spacing = 0;
    int          cs_low_cnt = 0;
    int          busy_cnt = 0;
    int          sclk_rises = 0;
    int          sclk_bad = 0;
    int          sclk_idle_bad = 0;
    int          last_rise = -1;
    int          ferr_cnt = 0;
    logic        sclk_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // ADC model: frame latched on CS fall, next bit presented on each SCLK rise.
    always @(negedge adc_cs_n) adc_sr = frame_bits;
    always @(posedge adc_sclk) begin
        adc_miso = adc_sr[215];
        adc_sr   = adc_sr << 1;
    end

    always @(negedge clk) begin
        if (word_if.adc_data_ready) begin
            if (last_strobe >= 0 && (cyc - last_strobe) != 192) bad_spacing++;
            last_strobe = cyc;
            strobe_sel.push_back(int'(word_if.adc_channel_sel));
            strobe_data.push_back(word_if.raw_adc_out);
        end
        if (!adc_cs_n) cs_low_cnt++;
        if (busy) busy_cnt++;
        if (adc_sclk && adc_cs_n) sclk_idle_bad++;
        if (adc_sclk && !sclk_prev) begin
            sclk_rises++;
            if (last_rise >= 0 && (cyc - last_rise) != 8) sclk_bad++;
            last_rise = cyc;
        end
        if (!adc_sclk && sclk_prev && (cyc - last_rise) != 4) sclk_bad++;
        sclk_prev = adc_sclk;
`ifdef ADC_STATUS_CHECK_EN
        if (frame_err) ferr_cnt++;
`endif
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic mon_clear();
        strobe_sel.delete();
        strobe_data.delete();
        last_strobe   = -1;
        bad_spacing   = 0;
        cs_low_cnt    = 0;
        busy_cnt      = 0;
        sclk_rises    = 0;
        sclk_bad      = 0;
        sclk_idle_bad = 0;
        last_rise     = -1;
        ferr_cnt      = 0;
    endtask

    task automatic pulse_drdy();
        @(negedge clk);
        adc_drdy_n = 1'b0;
        repeat (20) @(negedge clk);
        adc_drdy_n = 1'b1;
    endtask

    task automatic applyStimulus(input logic [23:0] status);
        frame_bits = '0;
        frame_bits[215 -: 24] = status;
        for (int i = 0; i < NUM_CH; i++) frame_bits[191 - 24*i -: 24] = ch[i];
        mon_clear();
        pulse_drdy();
    endtask

    task automatic wait_frame(input string tag);
        int  n;
        logic seen;
        n = 0;
        while (!busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        seen = busy;
        n = 0;
        while (busy && n < 3000) begin
            @(negedge clk);
            n++;
        end
        checkOutput(tag, {30'd0, seen, busy}, 32'h2);
    endtask

    task automatic check_frame(input string tag, input logic [23:0] status, input int exp_strobes);
        checkOutput({tag, "_strobe_count"}, 32'(strobe_data.size()), 32'(exp_strobes));
        for (int i = 0; i < strobe_data.size() && i < NUM_CH; i++) begin
            checkOutput($sformatf("%s_sel%0d", tag, i), 32'(strobe_sel[i]), 32'(i));
            checkOutput($sformatf("%s_data%0d", tag, i), {8'd0, strobe_data[i]}, {8'd0, ch[i]});
        end
        checkOutput({tag, "_spacing_errors"}, 32'(bad_spacing), 32'd0);
        checkOutput({tag, "_frame_status"}, {8'd0, frame_status}, {8'd0, status});
        checkOutput({tag, "_cs_low_cycles"}, 32'(cs_low_cnt), 32'd1736);
        checkOutput({tag, "_sclk_rises"}, 32'(sclk_rises), 32'd216);
        checkOutput({tag, "_sclk_phase_errors"}, 32'(sclk_bad), 32'd0);
        checkOutput({tag, "_sclk_idle_errors"}, 32'(sclk_idle_bad), 32'd0);
    endtask

    initial begin
        ch[0] = 24'h5DC000; ch[1] = 24'h000000; ch[2] = 24'hAA55AA; ch[3] = 24'h800000;
        ch[4] = 24'h7FFFFF; ch[5] = 24'h000001; ch[6] = 24'hFFFFFF; ch[7] = 24'h123456;

        repeat (3) @(negedge clk);
        checkOutput("reset_cs_n", 32'(adc_cs_n), 32'd1);
        checkOutput("reset_sclk", 32'(adc_sclk), 32'd0);
        checkOutput("reset_raw", {8'd0, word_if.raw_adc_out}, 32'd0);
        checkOutput("reset_sel", 32'(word_if.adc_channel_sel), 32'd0);
        checkOutput("reset_ready", 32'(word_if.adc_data_ready), 32'd0);
        checkOutput("reset_status", {8'd0, frame_status}, 32'd0);
        checkOutput("reset_overrun", 32'(frame_overrun), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        rst_n  = 1'b1;
        enable = 1'b1;
        repeat (5) @(negedge clk);

        applyStimulus(24'hC00000);
        wait_frame("frame1_done");
        check_frame("frame1", 24'hC00000, 8);
        checkOutput("frame1_raw_hold", {8'd0, word_if.raw_adc_out}, 32'h123456);
        checkOutput("frame1_sel_hold", 32'(word_if.adc_channel_sel), 32'd7);
        checkOutput("frame1_no_overrun", 32'(frame_overrun), 32'd0);

        applyStimulus(24'hC00000);
        repeat (480) @(negedge clk);
        pulse_drdy();
        wait_frame("overrun_frame_done");
        check_frame("overrun", 24'hC00000, 8);
        checkOutput("overrun_set", 32'(frame_overrun), 32'd1);
        repeat (30) @(negedge clk);
        checkOutput("overrun_edge_not_queued", 32'(busy), 32'd0);
        checkOutput("overrun_sticky", 32'(frame_overrun), 32'd1);
        clear_overrun = 1'b1;
        @(negedge clk);
        clear_overrun = 1'b0;
        checkOutput("overrun_cleared", 32'(frame_overrun), 32'd0);

        enable = 1'b0;
        applyStimulus(24'hC00000);
        repeat (60) @(negedge clk);
        checkOutput("disabled_cs_low", 32'(cs_low_cnt), 32'd0);
        checkOutput("disabled_busy", 32'(busy_cnt), 32'd0);
        checkOutput("disabled_sclk", 32'(sclk_rises), 32'd0);

        enable = 1'b1;
        applyStimulus(24'hC00000);
        repeat (300) @(negedge clk);
        enable = 1'b0;
        wait_frame("enable_drop_done");
        check_frame("enable_drop", 24'hC00000, 8);
        enable = 1'b1;
        repeat (10) @(negedge clk);

        applyStimulus(24'hC00000);
        repeat (800) @(negedge clk);
        checkOutput("pre_reset_busy", 32'(busy), 32'd1);
        checkOutput("pre_reset_raw", {8'd0, word_if.raw_adc_out}, 32'hAA55AA);
        checkOutput("pre_reset_sel", 32'(word_if.adc_channel_sel), 32'd2);
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("midreset_cs_n", 32'(adc_cs_n), 32'd1);
        checkOutput("midreset_sclk", 32'(adc_sclk), 32'd0);
        checkOutput("midreset_raw", {8'd0, word_if.raw_adc_out}, 32'd0);
        checkOutput("midreset_sel", 32'(word_if.adc_channel_sel), 32'd0);
        checkOutput("midreset_ready", 32'(word_if.adc_data_ready), 32'd0);
        checkOutput("midreset_status", {8'd0, frame_status}, 32'd0);
        checkOutput("midreset_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        applyStimulus(24'hC00000);
        wait_frame("recovery_done");
        check_frame("recovery", 24'hC00000, 8);

`ifdef ADC_STATUS_CHECK_EN
        repeat (10) @(negedge clk);
        applyStimulus(24'h400000);
        wait_frame("bad_header_done");
        check_frame("bad_header", 24'h400000, 0);
        checkOutput("bad_header_frame_err", 32'(ferr_cnt), 32'd1);
        repeat (10) @(negedge clk);
        applyStimulus(24'hC00000);
        wait_frame("good_header_done");
        check_frame("good_header", 24'hC00000, 8);
        checkOutput("good_header_frame_err", 32'(ferr_cnt), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
